stream_scoreboard: RTL

Synthesizable in-order checker for a single-stream DUT. Each accepted stimulus word is transformed by a fixed offset (`in_data + INC`, modulo 2^WIDTH) and queued as an expected value. Each observed DUT output word is compared against the oldest queued expectation. The block accumulates pass/fail statistics, captures the first mismatch, and flags unexpected outputs. It sits beside a DUT in simulation or on an FPGA self-test, and replaces file-driven compare loops.

---
 rtl/stream_scoreboard.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/stream_scoreboard.sv
// In-order stream checker: queues (in_data + INC) per accepted stimulus word and compares each observed word to the oldest entry.
// Latency: a push at edge N is comparable at edge N+1; compare results are registered at the edge that samples obs_valid.
// Backpressure: in_ready = not full, decoded from registered pending only; obs side is monitor-only and never stalls.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready/in_data  stimulus stream (valid/ready handshake)
//   obs_valid/obs_data       observed DUT output words
//   pending                  expectations currently queued (0..DEPTH)
//   pass_cnt/fail_cnt        saturating statistics
//   mismatch                 one-cycle pulse per failing compare or unexpected word
//   test_fail/unexpected     sticky failure flags
//   first_valid/first_exp/first_got  capture of the first failing event
module stream_scoreboard #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int INC   = 1,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     obs_valid,
  input  logic [WIDTH-1:0]         obs_data,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic                     mismatch,
  output logic                     test_fail,
  output logic                     unexpected,
  output logic                     first_valid,
  output logic [WIDTH-1:0]         first_exp,
  output logic [WIDTH-1:0]         first_got
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    pending_q, pending_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             mismatch_q, mismatch_d;
  logic             test_fail_q, test_fail_d;
  logic             unexpected_q, unexpected_d;
  logic             first_valid_q, first_valid_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;

  logic             push;
  logic             pop;
  logic             unexp_evt;
  logic             hit;
  logic             miss;
  logic [WIDTH-1:0] head;

  // Ready depends only on registered occupancy, so a pop in the same cycle
  // never frees a slot for a push while full.
  assign in_ready = (pending_q != DEPTH_P);

  always_comb begin
    push      = in_valid && in_ready;
    // No bypass: an observation is judged against the queue as it stood
    // before this edge, so a same-cycle push into an empty FIFO is unexpected.
    pop       = obs_valid && (pending_q != '0);
    unexp_evt = obs_valid && (pending_q == '0);
    head      = mem_q[rd_ptr_q];
    hit       = pop && (head == obs_data);
    miss      = (pop && (head != obs_data)) || unexp_evt;

    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pending_d     = pending_q;
    pass_cnt_d    = pass_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    mismatch_d    = miss;
    test_fail_d   = test_fail_q;
    unexpected_d  = unexpected_q;
    first_valid_d = first_valid_q;
    first_exp_d   = first_exp_q;
    first_got_d   = first_got_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase

    // Counters saturate at all-ones rather than wrapping.
    if (hit && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + CNT_W'(1);
    if (miss && (fail_cnt_q != '1)) fail_cnt_d = fail_cnt_q + CNT_W'(1);

    if (miss)      test_fail_d  = 1'b1;
    if (unexp_evt) unexpected_d = 1'b1;

    if (miss && !first_valid_q) begin
      first_valid_d = 1'b1;
      first_exp_d   = unexp_evt ? '0 : head;
      first_got_d   = obs_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pending_q     <= '0;
      pass_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      mismatch_q    <= 1'b0;
      test_fail_q   <= 1'b0;
      unexpected_q  <= 1'b0;
      first_valid_q <= 1'b0;
      first_exp_q   <= '0;
      first_got_q   <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pending_q     <= pending_d;
      pass_cnt_q    <= pass_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      mismatch_q    <= mismatch_d;
      test_fail_q   <= test_fail_d;
      unexpected_q  <= unexpected_d;
      first_valid_q <= first_valid_d;
      first_exp_q   <= first_exp_d;
      first_got_q   <= first_got_d;
    end
  end

  // Storage needs no reset: entries are only read when pending says valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= in_data + INC_W;
  end

  assign pending     = pending_q;
  assign pass_cnt    = pass_cnt_q;
  assign fail_cnt    = fail_cnt_q;
  assign mismatch    = mismatch_q;
  assign test_fail   = test_fail_q;
  assign unexpected  = unexpected_q;
  assign first_valid = first_valid_q;
  assign first_exp   = first_exp_q;
  assign first_got   = first_got_q;

endmodule
